// File: rtl/memaccess_log.sv
// rtl/memaccess_log.sv - range-hit event logger with event FIFO, write-hit counter and alert FSM
module memaccess_log #(
    parameter int DEPTH    = 4,
    parameter int WR_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        rd_hit,
    input  logic        wr_hit,
    input  logic        pop,
    input  logic        clr,
    output logic        evt_valid,
    output logic [31:0] evt_addr,
    output logic        evt_wr,
    output logic [15:0] wr_count,
    output logic        overflow,
    output logic        irq
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
    localparam logic [15:0] LIMIT = 16'(WR_LIMIT);

    typedef enum logic {MONITOR, ALERT} state_t;

    state_t          state;
    logic [31:0]     addr_q;
    logic [31:0]     mem_addr [DEPTH];
    logic            mem_wr   [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     count;

    logic            push;
    logic            do_pop;
    logic            accept;
    logic            drop;
    logic [15:0]     wr_count_nxt;
    logic            overflow_nxt;

    always_comb begin
        push   = rd_hit | wr_hit;
        do_pop = pop && (count != '0);
        // A full FIFO can still take a push when the head leaves the same cycle.
        accept = push && ((count != FULL) || do_pop);
        drop   = push && (count == FULL) && !do_pop;
        if (clr)
            wr_count_nxt = 16'h0000;
        else if (wr_hit && (wr_count != 16'hFFFF))
            wr_count_nxt = wr_count + 16'h0001;
        else
            wr_count_nxt = wr_count;
        overflow_nxt = clr ? 1'b0 : (overflow | drop);
    end

    assign evt_valid = (count != '0);
    assign evt_addr  = evt_valid ? mem_addr[rptr] : 32'h0;
    assign evt_wr    = evt_valid ? mem_wr[rptr]   : 1'b0;

    // Storage needs no reset: outputs are masked by the reset-cleared occupancy.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_addr[wptr] <= addr_q;
            mem_wr[wptr]   <= wr_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= 32'h0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            wr_count <= 16'h0000;
            overflow <= 1'b0;
            state    <= MONITOR;
            irq      <= 1'b0;
        end else begin
            addr_q   <= addr;
            wr_count <= wr_count_nxt;
            overflow <= overflow_nxt;
            if (accept)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            if (accept && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !accept)
                count <= count - 1'b1;

            case (state)
                MONITOR: begin
                    if (!clr && ((wr_count_nxt >= LIMIT) || overflow_nxt)) begin
                        state <= ALERT;
                        irq   <= 1'b1;
                    end
                end
                ALERT: begin
                    if (clr) begin
                        state <= MONITOR;
                        irq   <= 1'b0;
                    end
                end
                default: begin
                    state <= MONITOR;
                    irq   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memaccess_log.sv
// tb/tb_memaccess_log.sv - directed and random checks of memaccess_log against a queue model
module tb_memaccess_log;
    localparam int DEPTH    = 4;
    localparam int WR_LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        rd_hit, wr_hit, pop, clr;
    logic        evt_valid;
    logic [31:0] evt_addr;
    logic        evt_wr;
    logic [15:0] wr_count;
    logic        overflow;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // model: event queue plus counters, updated once per rising edge
    logic [32:0] m_q[$];
    logic [31:0] m_addr_q;
    int          m_cnt;
    bit          m_ovf;
    bit          m_alert;

    memaccess_log #(.DEPTH(DEPTH), .WR_LIMIT(WR_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd_hit(rd_hit), .wr_hit(wr_hit),
        .pop(pop), .clr(clr), .evt_valid(evt_valid), .evt_addr(evt_addr),
        .evt_wr(evt_wr), .wr_count(wr_count), .overflow(overflow), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_addr_q = 32'h0;
        m_cnt    = 0;
        m_ovf    = 0;
        m_alert  = 0;
    endtask

    task automatic check_all(input string tag);
        bit          v;
        logic [32:0] h;
        v = (m_q.size() != 0);
        h = v ? m_q[0] : 33'h0;
        check({tag, ".evt_valid"}, {31'h0, evt_valid}, {31'h0, v});
        check({tag, ".evt_addr"},  evt_addr, h[32:1]);
        check({tag, ".evt_wr"},    {31'h0, evt_wr}, {31'h0, h[0]});
        check({tag, ".wr_count"},  {16'h0, wr_count}, m_cnt);
        check({tag, ".overflow"},  {31'h0, overflow}, {31'h0, m_ovf});
        check({tag, ".irq"},       {31'h0, irq}, {31'h0, m_alert});
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic step(input logic [31:0] a, input bit rd, input bit wr,
                        input bit p, input bit c, input string tag);
        bit popped;
        addr = a; rd_hit = rd; wr_hit = wr; pop = p; clr = c;
        popped = p && (m_q.size() != 0);
        if (popped) void'(m_q.pop_front());
        if (rd || wr) begin
            if (m_q.size() < DEPTH) m_q.push_back({m_addr_q, wr});
            else m_ovf = 1;
        end
        m_addr_q = a;
        if (wr && m_cnt < 16'hFFFF) m_cnt++;
        if (c) begin
            m_cnt = 0; m_ovf = 0; m_alert = 0;
        end else if (m_cnt >= WR_LIMIT || m_ovf) begin
            m_alert = 1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        addr = 0; rd_hit = 0; wr_hit = 0; pop = 0; clr = 0;
        rst_n = 0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1;
        @(posedge clk); #1;

        // single read hit lands one cycle after its address
        step(32'h4, 0, 0, 0, 0, "rd.addr");
        step(32'h0, 1, 0, 0, 0, "rd.hit");
        step(32'h0, 0, 0, 1, 0, "rd.pop");

        // three write hits raise the alert; clr drops it but keeps entries
        step(32'h0, 0, 0, 0, 0, "wr.a0");
        step(32'h1, 0, 1, 0, 0, "wr.h0");
        step(32'h2, 0, 1, 0, 0, "wr.h1");
        step(32'h3, 0, 1, 0, 0, "wr.h2");
        check("wr.entries", m_q.size(), 3);
        step(32'h3, 0, 0, 0, 1, "wr.clr");
        for (int i = 0; i < 3; i++) step(32'h0, 0, 0, 1, 0, "wr.drain");

        // five read hits into a four-deep FIFO: last one dropped
        for (int i = 0; i < 6; i++) step(32'h100 + i, (i != 0), 0, 0, 0, "ovf.fill");
        step(32'h0, 0, 0, 0, 0, "ovf.hold");

        // full FIFO with hit and pop together: no further overflow after clr
        step(32'h0, 0, 0, 0, 1, "full.clr");
        step(32'h200, 1, 0, 1, 0, "full.hitpop");
        step(32'h0, 0, 0, 0, 0, "full.after");

        // simultaneous read and write hit gives one write entry
        for (int i = 0; i < 4; i++) step(32'h0, 0, 0, 1, 1, "both.drain");
        step(32'h300, 0, 0, 0, 0, "both.addr");
        step(32'h0, 1, 1, 0, 0, "both.hit");

        // clr wins over a same-cycle write hit
        step(32'h0, 0, 1, 0, 1, "clrwr");

        // asynchronous reset between edges with entries and irq set
        step(32'h10, 0, 1, 0, 0, "ar.w0");
        step(32'h11, 0, 1, 0, 0, "ar.w1");
        step(32'h12, 0, 1, 1, 0, "ar.w2");
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_all("ar.async");
        @(posedge clk); #3;
        rst_n = 1;
        #3;
        step(32'h20, 0, 0, 0, 0, "ar.resume0");
        step(32'h0, 0, 1, 0, 0, "ar.resume1");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
